// File: rtl/traffic_lamp_monitor.sv
// ============================================================================
// Module      : traffic_lamp_monitor
// Description : Independent lamp-side safety checker for the two-road
//               intersection controller. Tracks the expected phase sequence
//               and raises sticky faults for illegal codes, conflicting
//               greens/yellows, out-of-order transitions, dwell violations
//               and enable mismatches. fault_any requests fail-safe flashing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_lamp_monitor #(
  parameter int YEL_MIN = 2,
  parameter int YEL_MAX = 8,
  parameter int GRN_MIN = 8,
  parameter int GRN_MAX = 16,
  parameter int DW_W    = 6,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       road1_in,
  input  logic [2:0]       road2_in,
  input  logic             en_in,
  input  logic             clear,
  output logic [2:0]       phase,
  output logic             f_code,
  output logic             f_conflict,
  output logic             f_seq,
  output logic             f_dwell,
  output logic             f_en,
  output logic             fault_any,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_Y1A  = 3'd1,
    S_G1   = 3'd2,
    S_Y1B  = 3'd3,
    S_Y2A  = 3'd4,
    S_G2   = 3'd5,
    S_Y2B  = 3'd6,
    S_SYNC = 3'd7
  } phase_t;

  // Lamp codes
  localparam logic [2:0] c_RED = 3'b001;
  localparam logic [2:0] c_YEL = 3'b010;
  localparam logic [2:0] c_GRN = 3'b100;

  // Identifiers for the five legal lamp pairs (road1/road2)
  localparam logic [2:0] c_P_RR  = 3'd0;
  localparam logic [2:0] c_P_YR  = 3'd1;
  localparam logic [2:0] c_P_GR  = 3'd2;
  localparam logic [2:0] c_P_RY  = 3'd3;
  localparam logic [2:0] c_P_RG  = 3'd4;
  localparam logic [2:0] c_P_BAD = 3'd7;

  localparam logic [DW_W-1:0]  c_YEL_MIN = DW_W'(YEL_MIN);
  localparam logic [DW_W-1:0]  c_YEL_MAX = DW_W'(YEL_MAX);
  localparam logic [DW_W-1:0]  c_GRN_MIN = DW_W'(GRN_MIN);
  localparam logic [DW_W-1:0]  c_GRN_MAX = DW_W'(GRN_MAX);
  localparam logic [DW_W-1:0]  c_DW_ONE  = DW_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  phase_t           r_phase;
  logic [DW_W-1:0]  r_dwell;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic             r_f_code;
  logic             r_f_conflict;
  logic             r_f_seq;
  logic             r_f_dwell;
  logic             r_f_en;

  logic             w_ok1;
  logic             w_ok2;
  logic             w_rr;
  logic             w_new_code;
  logic             w_new_conf;
  logic             w_new_en;
  logic [2:0]       w_pair;
  logic [2:0]       w_hold;
  logic [2:0]       w_next;
  phase_t           w_adv;
  logic             w_timed;
  logic [DW_W-1:0]  w_min;
  logic [DW_W-1:0]  w_max;
  logic [DW_W-1:0]  w_dwell_inc;
  phase_t           w_next_phase;
  logic             w_new_seq;
  logic             w_new_dwell;
  logic             w_cycle_done;

  assign w_ok1 = (road1_in == c_RED) || (road1_in == c_YEL) || (road1_in == c_GRN);
  assign w_ok2 = (road2_in == c_RED) || (road2_in == c_YEL) || (road2_in == c_GRN);
  assign w_rr  = (road1_in == c_RED) && (road2_in == c_RED);

  // Code and conflict faults are independent of the tracked phase
  assign w_new_code = !(w_ok1 && w_ok2);
  assign w_new_conf = w_ok1 && w_ok2 && (road1_in != c_RED) && (road2_in != c_RED);
  // The controller must enable exactly when some lamp is not red
  assign w_new_en   = (en_in != !w_rr);

  assign w_dwell_inc = (&r_dwell) ? r_dwell : (r_dwell + c_DW_ONE);

  // Classify the sampled lamp pair
  always_comb begin
    w_pair = c_P_BAD;
    if (w_rr)                                         w_pair = c_P_RR;
    else if (road1_in == c_YEL && road2_in == c_RED)  w_pair = c_P_YR;
    else if (road1_in == c_GRN && road2_in == c_RED)  w_pair = c_P_GR;
    else if (road1_in == c_RED && road2_in == c_YEL)  w_pair = c_P_RY;
    else if (road1_in == c_RED && road2_in == c_GRN)  w_pair = c_P_RG;
  end

  // Per-phase hold pair, advance pair, successor phase and dwell limits
  always_comb begin
    w_hold  = c_P_BAD;
    w_next  = c_P_BAD;
    w_adv   = S_SYNC;
    w_timed = 1'b0;
    w_min   = '0;
    w_max   = '0;
    case (r_phase)
      S_IDLE: begin w_hold = c_P_RR; w_next = c_P_YR; w_adv = S_Y1A; end
      S_Y1A:  begin w_hold = c_P_YR; w_next = c_P_GR; w_adv = S_G1;
                    w_timed = 1'b1; w_min = c_YEL_MIN; w_max = c_YEL_MAX; end
      S_G1:   begin w_hold = c_P_GR; w_next = c_P_YR; w_adv = S_Y1B;
                    w_timed = 1'b1; w_min = c_GRN_MIN; w_max = c_GRN_MAX; end
      S_Y1B:  begin w_hold = c_P_YR; w_next = c_P_RY; w_adv = S_Y2A;
                    w_timed = 1'b1; w_min = c_YEL_MIN; w_max = c_YEL_MAX; end
      S_Y2A:  begin w_hold = c_P_RY; w_next = c_P_RG; w_adv = S_G2;
                    w_timed = 1'b1; w_min = c_YEL_MIN; w_max = c_YEL_MAX; end
      S_G2:   begin w_hold = c_P_RG; w_next = c_P_RY; w_adv = S_Y2B;
                    w_timed = 1'b1; w_min = c_GRN_MIN; w_max = c_GRN_MAX; end
      S_Y2B:  begin w_hold = c_P_RY; w_next = c_P_RR; w_adv = S_IDLE;
                    w_timed = 1'b1; w_min = c_YEL_MIN; w_max = c_YEL_MAX; end
      default: ;
    endcase
  end

  // Next phase plus sequence/dwell fault detection; code faults dominate
  always_comb begin
    w_next_phase = r_phase;
    w_new_seq    = 1'b0;
    w_new_dwell  = 1'b0;
    w_cycle_done = 1'b0;
    if (w_new_code || w_new_conf) begin
      w_next_phase = S_SYNC;
    end else if (r_phase == S_SYNC) begin
      if (w_rr) w_next_phase = S_IDLE;
    end else if (w_pair == w_hold) begin
      // Holding too long: the controller is stuck, resynchronise
      if (w_timed && (w_dwell_inc >= w_max)) begin
        w_new_dwell  = 1'b1;
        w_next_phase = S_SYNC;
      end
    end else if (w_pair == w_next) begin
      // Leaving too early is flagged but the sequence is still followed
      if (w_timed && (r_dwell < w_min)) w_new_dwell = 1'b1;
      w_next_phase = w_adv;
      w_cycle_done = (r_phase == S_Y2B);
    end else begin
      w_new_seq    = 1'b1;
      w_next_phase = S_SYNC;
    end
  end

  // Phase tracker, dwell counter, sticky flags and cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase      <= S_SYNC;
      r_dwell      <= '0;
      r_cycle_cnt  <= '0;
      r_f_code     <= 1'b0;
      r_f_conflict <= 1'b0;
      r_f_seq      <= 1'b0;
      r_f_dwell    <= 1'b0;
      r_f_en       <= 1'b0;
    end else begin
      r_phase      <= w_next_phase;
      r_dwell      <= (w_next_phase != r_phase) ? c_DW_ONE : w_dwell_inc;
      if (w_cycle_done) r_cycle_cnt <= r_cycle_cnt + c_CNT_ONE;
      // A fault detected on the clearing edge still sets its flag
      r_f_code     <= (r_f_code     && !clear) || w_new_code;
      r_f_conflict <= (r_f_conflict && !clear) || w_new_conf;
      r_f_seq      <= (r_f_seq      && !clear) || w_new_seq;
      r_f_dwell    <= (r_f_dwell    && !clear) || w_new_dwell;
      r_f_en       <= (r_f_en       && !clear) || w_new_en;
    end
  end

  assign phase      = r_phase;
  assign f_code     = r_f_code;
  assign f_conflict = r_f_conflict;
  assign f_seq      = r_f_seq;
  assign f_dwell    = r_f_dwell;
  assign f_en       = r_f_en;
  assign fault_any  = r_f_code | r_f_conflict | r_f_seq | r_f_dwell | r_f_en;
  assign cycle_cnt  = r_cycle_cnt;

endmodule

`default_nettype wire

// File: tb/tb_traffic_lamp_monitor.sv
// ============================================================================
// Module      : tb_traffic_lamp_monitor
// Description : Self-checking bench for traffic_lamp_monitor. A behavioural
//               model predicts phase/flags/counter for every sample; the
//               expectations are queued and compared one edge later. Each
//               scenario task also checks its key outcomes directly.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_lamp_monitor;

  localparam logic [2:0] R = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b100;

  typedef struct {
    logic [2:0]  phase;
    logic [4:0]  flags;   // {code, conflict, seq, dwell, en}
    logic [15:0] cnt;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [2:0]  road1_in;
  logic [2:0]  road2_in;
  logic        en_in;
  logic        clear;
  logic [2:0]  phase;
  logic        f_code, f_conflict, f_seq, f_dwell, f_en, fault_any;
  logic [15:0] cycle_cnt;

  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];

  // Reference model state
  int          m_phase;
  int          m_dwell;
  logic [4:0]  m_flags;
  logic [15:0] m_cnt;

  int hold_tab[7] = '{0, 1, 2, 1, 3, 4, 3};
  int next_tab[7] = '{1, 2, 1, 3, 4, 3, 0};

  traffic_lamp_monitor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .road1_in   (road1_in),
    .road2_in   (road2_in),
    .en_in      (en_in),
    .clear      (clear),
    .phase      (phase),
    .f_code     (f_code),
    .f_conflict (f_conflict),
    .f_seq      (f_seq),
    .f_dwell    (f_dwell),
    .f_en       (f_en),
    .fault_any  (fault_any),
    .cycle_cnt  (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pair_id(input logic [2:0] a, input logic [2:0] b);
    case ({a, b})
      6'b001_001: return 0;
      6'b010_001: return 1;
      6'b100_001: return 2;
      6'b001_010: return 3;
      6'b001_100: return 4;
      default:    return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 7;
    m_dwell = 0;
    m_flags = '0;
    m_cnt   = '0;
    sb_q.delete();
  endtask

  // Drive one sample at the falling edge and queue the predicted outcome
  task automatic step(input logic [2:0] a, input logic [2:0] b,
                      input logic en_bad, input logic clr);
    logic       ok1, ok2, rr, timed;
    logic [4:0] nf;
    int         np, mn, mx;
    exp_t       e;
    @(negedge clk);
    rr       = (a == R) && (b == R);
    road1_in = a;
    road2_in = b;
    en_in    = (!rr) ^ en_bad;
    clear    = clr;
    ok1 = (a == R) || (a == Y) || (a == G);
    ok2 = (b == R) || (b == Y) || (b == G);
    nf    = '0;
    nf[4] = !(ok1 && ok2);
    nf[3] = ok1 && ok2 && (a != R) && (b != R);
    nf[0] = (en_in != !rr);
    np    = m_phase;
    timed = (m_phase >= 1) && (m_phase <= 6);
    mn = ((m_phase == 2) || (m_phase == 5)) ? 8 : 2;
    mx = ((m_phase == 2) || (m_phase == 5)) ? 16 : 8;
    if (nf[4] || nf[3]) begin
      np = 7;
    end else if (m_phase == 7) begin
      if (rr) np = 0;
    end else if (pair_id(a, b) == hold_tab[m_phase]) begin
      if (timed && (m_dwell + 1 >= mx)) begin
        nf[1] = 1'b1;
        np    = 7;
      end
    end else if (pair_id(a, b) == next_tab[m_phase]) begin
      if (timed && (m_dwell < mn)) nf[1] = 1'b1;
      if (m_phase == 6) begin
        np    = 0;
        m_cnt = m_cnt + 16'd1;
      end else begin
        np = m_phase + 1;
      end
    end else begin
      nf[2] = 1'b1;
      np    = 7;
    end
    if (np != m_phase)   m_dwell = 1;
    else if (m_dwell < 63) m_dwell = m_dwell + 1;
    m_phase = np;
    m_flags = (clr ? 5'b0 : m_flags) | nf;
    e.phase = 3'(m_phase);
    e.flags = m_flags;
    e.cnt   = m_cnt;
    sb_q.push_back(e);
  endtask

  task automatic hold(input logic [2:0] a, input logic [2:0] b, input int n);
    repeat (n) step(a, b, 1'b0, 1'b0);
  endtask

  task automatic run_cycle(input int gtime);
    hold(Y, R, 2);
    hold(G, R, gtime);
    hold(Y, R, 2);
    hold(R, Y, 2);
    hold(R, G, gtime);
    hold(R, Y, 2);
    hold(R, R, 1);
  endtask

  // Scoreboard: each queued prediction is compared just after its edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_checks = n_checks + 1;
      if (phase !== e.phase || {f_code, f_conflict, f_seq, f_dwell, f_en} !== e.flags ||
          cycle_cnt !== e.cnt || fault_any !== (|e.flags)) begin
        n_fail = n_fail + 1;
        $display("FAIL scoreboard t=%0t: got phase=%0d flags=%b any=%b cnt=%0d, expected phase=%0d flags=%b any=%b cnt=%0d",
                 $time, phase, {f_code, f_conflict, f_seq, f_dwell, f_en}, fault_any, cycle_cnt,
                 e.phase, e.flags, |e.flags, e.cnt);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; road1_in = R; road2_in = R; en_in = 1'b0; clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (phase !== 3'd7 || {f_code, f_conflict, f_seq, f_dwell, f_en} !== 5'b0 ||
        fault_any !== 1'b0 || cycle_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: phase=%0d flags=%b any=%b cnt=%0d, expected 7/00000/0/0",
               phase, {f_code, f_conflict, f_seq, f_dwell, f_en}, fault_any, cycle_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full_cycle();
    step(R, R, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if (phase !== 3'd0) begin
      n_fail++; $display("FAIL sync_to_idle: phase=%0d expected 0", phase);
    end
    hold(R, R, 2);
    run_cycle(10);
    @(posedge clk); #1;
    n_checks++;
    if (phase !== 3'd0 || cycle_cnt !== 16'd1 || fault_any !== 1'b0) begin
      n_fail++;
      $display("FAIL full_cycle: phase=%0d cnt=%0d any=%b expected 0/1/0", phase, cycle_cnt, fault_any);
    end
  endtask

  task automatic test_conflict();
    hold(Y, R, 2);
    hold(G, R, 3);
    step(G, G, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if (f_conflict !== 1'b1 || fault_any !== 1'b1 || phase !== 3'd7) begin
      n_fail++;
      $display("FAIL conflict: f_conflict=%b any=%b phase=%0d expected 1/1/7", f_conflict, fault_any, phase);
    end
    step(R, R, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if (phase !== 3'd0 || f_conflict !== 1'b1) begin
      n_fail++;
      $display("FAIL conflict_sticky: phase=%0d f_conflict=%b expected 0/1", phase, f_conflict);
    end
    step(R, R, 1'b0, 1'b1);
  endtask

  task automatic test_code();
    step(3'b011, R, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if (f_code !== 1'b1 || phase !== 3'd7 || f_seq !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_code: f_code=%b phase=%0d f_seq=%b expected 1/7/0", f_code, phase, f_seq);
    end
    step(R, R, 1'b0, 1'b1);
  endtask

  task automatic test_dwell();
    hold(Y, R, 2);
    hold(G, R, 3);
    step(Y, R, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if (f_dwell !== 1'b1 || phase !== 3'd3) begin
      n_fail++;
      $display("FAIL dwell_short: f_dwell=%b phase=%0d expected 1/3", f_dwell, phase);
    end
    step(R, R, 1'b0, 1'b1);
    step(R, R, 1'b0, 1'b1);
    hold(Y, R, 2);
    hold(G, R, 15);
    @(posedge clk); #1;
    n_checks++;
    if (f_dwell !== 1'b0 || phase !== 3'd2) begin
      n_fail++;
      $display("FAIL dwell_below_max: f_dwell=%b phase=%0d expected 0/2", f_dwell, phase);
    end
    step(G, R, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if (f_dwell !== 1'b1 || phase !== 3'd7) begin
      n_fail++;
      $display("FAIL dwell_max: f_dwell=%b phase=%0d expected 1/7", f_dwell, phase);
    end
    step(R, R, 1'b0, 1'b0);
    step(R, R, 1'b0, 1'b1);
  endtask

  task automatic test_seq_en();
    step(G, R, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if (f_seq !== 1'b1 || phase !== 3'd7) begin
      n_fail++;
      $display("FAIL seq_skip: f_seq=%b phase=%0d expected 1/7", f_seq, phase);
    end
    step(R, R, 1'b0, 1'b0);
    step(R, R, 1'b1, 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if (f_en !== 1'b1 || phase !== 3'd0) begin
      n_fail++;
      $display("FAIL enable_mismatch: f_en=%b phase=%0d expected 1/0", f_en, phase);
    end
  endtask

  task automatic test_clear();
    step(R, R, 1'b0, 1'b1);
    @(posedge clk); #1;
    n_checks++;
    if ({f_code, f_conflict, f_seq, f_dwell, f_en} !== 5'b0 || fault_any !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_idle: flags=%b any=%b expected 00000/0",
               {f_code, f_conflict, f_seq, f_dwell, f_en}, fault_any);
    end
    step(R, R, 1'b1, 1'b0);
    step(G, G, 1'b0, 1'b1);
    @(posedge clk); #1;
    n_checks++;
    if ({f_code, f_conflict, f_seq, f_dwell, f_en} !== 5'b01000 || phase !== 3'd7) begin
      n_fail++;
      $display("FAIL clear_vs_conflict: flags=%b phase=%0d expected 01000/7",
               {f_code, f_conflict, f_seq, f_dwell, f_en}, phase);
    end
  endtask

  task automatic test_back_to_back();
    step(R, R, 1'b0, 1'b1);
    run_cycle(8);
    run_cycle(12);
    @(posedge clk); #1;
    n_checks++;
    if (cycle_cnt !== 16'd3 || phase !== 3'd0 || fault_any !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back: cnt=%0d phase=%0d any=%b expected 3/0/0", cycle_cnt, phase, fault_any);
    end
    step(Y, R, 1'b0, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (phase !== 3'd7 || cycle_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL async_reset: phase=%0d cnt=%0d expected 7/0", phase, cycle_cnt);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_full_cycle();
    test_conflict();
    test_code();
    test_dwell();
    test_seq_en();
    test_clear();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
